// File: rtl/err_inj_pkg.sv
// Shared types, constants and helpers for the Hamming-path error-injection generator.
package err_inj_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'b00,
      SINGLE = 2'b01,
      DOUBLE = 2'b10,
      RSVD   = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      DONE  = 2'b10
   } state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Folds an LFSR slice into [0, data_w); the slice is always below 2*data_w.
   function automatic int unsigned pos_wrap(input int unsigned r, input int unsigned data_w);
      return (r < data_w) ? r : r - data_w;
   endfunction

endpackage

// File: rtl/err_inj_lane.sv
// One injection channel: arm/disarm FSM, beat-period counter, mask build,
// registered data path and saturating injection counter.
module err_inj_lane
   import err_inj_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16,
   parameter int POS_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_we_i,
   input  logic              cfg_arm_i,
   input  mode_e             mode_i,
   input  logic              oneshot_i,
   input  logic [POS_W-1:0]  pos0_i,
   input  logic [POS_W-1:0]  pos1_i,
   input  logic [CNT_W-1:0]  period_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              inj_o,
   output logic              dbit_o,
   output logic [CNT_W-1:0]  inj_cnt_o
);

   localparam logic [POS_W:0] DATA_W_P = (POS_W + 1)'(DATA_W);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  period_m1;
   logic              hit;
   logic              pos0_ok;
   logic              pos1_ok;
   logic [DATA_W-1:0] mask_d;
   logic              dbit_d;
   logic              inj_d;
   logic [CNT_W-1:0]  inj_cnt_d;

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic              inj_q;
   logic              dbit_q;
   logic [CNT_W-1:0]  inj_cnt_q;

   assign period_m1 = (period_i == '0) ? '0 : period_i - 1'b1;
   assign hit       = valid_i && (state_q == ARMED) && (cnt_q == period_m1);
   assign pos0_ok   = {1'b0, pos0_i} < DATA_W_P;
   assign pos1_ok   = {1'b0, pos1_i} < DATA_W_P;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      mask_d = '0;
      dbit_d = 1'b0;
      if (hit) begin
         if (((mode_i == SINGLE) || (mode_i == DOUBLE)) && pos0_ok) mask_d[pos0_i] = 1'b1;
         if ((mode_i == DOUBLE) && pos1_ok) mask_d[pos1_i] = 1'b1;
         dbit_d = (mode_i == DOUBLE) && pos0_ok && pos1_ok && (pos0_i != pos1_i);
      end
   end

   assign inj_d     = |mask_d;
   assign inj_cnt_d = (inj_d && (inj_cnt_q != '1)) ? inj_cnt_q + 1'b1 : inj_cnt_q;

   // A configuration write overrides whatever the coincident beat would have done.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (cfg_we_i) begin
         cnt_q   <= '0;
         state_q <= cfg_arm_i ? ARMED : IDLE;
      end else if (valid_i && (state_q == ARMED)) begin
         if (hit) begin
            cnt_q <= '0;
            if (oneshot_i) state_q <= DONE;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         inj_q     <= 1'b0;
         dbit_q    <= 1'b0;
         inj_cnt_q <= '0;
      end else begin
         valid_q   <= valid_i;
         data_q    <= data_i ^ mask_d;
         inj_q     <= inj_d;
         dbit_q    <= dbit_d;
         inj_cnt_q <= inj_cnt_d;
      end
   end

   assign valid_o   = valid_q;
   assign data_o    = data_q;
   assign inj_o     = inj_q;
   assign dbit_o    = dbit_q;
   assign inj_cnt_o = inj_cnt_q;

endmodule

// File: rtl/err_inj_gen.sv
// Multi-channel error-injection generator: shared LFSR and configuration
// registers fanned out to one err_inj_lane per encoded-word channel.
module err_inj_gen
   import err_inj_pkg::*;
#(
   parameter int          DATA_W    = 16,
   parameter int          NUM_CH    = 2,
   parameter int          CNT_W     = 16,
   parameter int          POS_W     = $clog2(DATA_W),
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_cfg_we,
   input  logic [1:0]               i_cfg_mode,
   input  logic                     i_cfg_rand,
   input  logic                     i_cfg_oneshot,
   input  logic [POS_W-1:0]         i_cfg_pos0,
   input  logic [POS_W-1:0]         i_cfg_pos1,
   input  logic [CNT_W-1:0]         i_cfg_period,
   input  logic [NUM_CH-1:0]        i_cfg_ch_en,
   input  logic [NUM_CH-1:0]        i_valid,
   input  logic [NUM_CH*DATA_W-1:0] i_data,
   output logic [NUM_CH-1:0]        o_valid,
   output logic [NUM_CH*DATA_W-1:0] o_data,
   output logic [NUM_CH-1:0]        o_inj,
   output logic [NUM_CH-1:0]        o_dbit,
   output logic [NUM_CH*CNT_W-1:0]  o_inj_cnt
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   mode_e            cfg_mode_q;
   logic             cfg_rand_q;
   logic             cfg_oneshot_q;
   logic [POS_W-1:0] cfg_pos0_q;
   logic [POS_W-1:0] cfg_pos1_q;
   logic [CNT_W-1:0] cfg_period_q;

   logic [15:0]      lfsr_q;
   logic [15:0]      lfsr_d;
   logic [POS_W-1:0] rnd_p0;
   logic [POS_W-1:0] rnd_p1;
   logic [POS_W-1:0] pos0;
   logic [POS_W-1:0] pos1;
   logic             cfg_arm;

   assign cfg_arm = (i_cfg_mode == SINGLE) || (i_cfg_mode == DOUBLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cfg_mode_q    <= OFF;
         cfg_rand_q    <= 1'b0;
         cfg_oneshot_q <= 1'b0;
         cfg_pos0_q    <= '0;
         cfg_pos1_q    <= '0;
         cfg_period_q  <= '0;
      end else if (i_cfg_we) begin
         cfg_mode_q    <= mode_e'(i_cfg_mode);
         cfg_rand_q    <= i_cfg_rand;
         cfg_oneshot_q <= i_cfg_oneshot;
         cfg_pos0_q    <= i_cfg_pos0;
         cfg_pos1_q    <= i_cfg_pos1;
         cfg_period_q  <= i_cfg_period;
      end
   end

   assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) lfsr_q <= SEED_EFF;
      else          lfsr_q <= lfsr_d;
   end

   assign rnd_p0 = POS_W'(pos_wrap(32'(lfsr_q[POS_W-1:0]), DATA_W));
   assign rnd_p1 = ({1'b0, rnd_p0} == (POS_W + 1)'(DATA_W - 1)) ? '0 : rnd_p0 + 1'b1;
   assign pos0   = cfg_rand_q ? rnd_p0 : cfg_pos0_q;
   assign pos1   = cfg_rand_q ? rnd_p1 : cfg_pos1_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      err_inj_lane #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W),
         .POS_W  (POS_W)
      ) u_lane (
         .clk_i     (i_clk),
         .rst_ni    (i_rst_n),
         .cfg_we_i  (i_cfg_we),
         .cfg_arm_i (cfg_arm && i_cfg_ch_en[c]),
         .mode_i    (cfg_mode_q),
         .oneshot_i (cfg_oneshot_q),
         .pos0_i    (pos0),
         .pos1_i    (pos1),
         .period_i  (cfg_period_q),
         .valid_i   (i_valid[c]),
         .data_i    (i_data[c*DATA_W +: DATA_W]),
         .valid_o   (o_valid[c]),
         .data_o    (o_data[c*DATA_W +: DATA_W]),
         .inj_o     (o_inj[c]),
         .dbit_o    (o_dbit[c]),
         .inj_cnt_o (o_inj_cnt[c*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_err_inj_gen.sv
// Self-checking bench for err_inj_gen: behavioural model of the injection rules,
// directed cases with literal expectations, then randomized configuration/traffic.
module tb_err_inj_gen;

   localparam int DW = 16;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [1:0]  cfg_mode;
   logic        cfg_rand;
   logic        cfg_oneshot;
   logic [3:0]  cfg_pos0;
   logic [3:0]  cfg_pos1;
   logic [15:0] cfg_period;
   logic [1:0]  cfg_ch_en;
   logic [1:0]  vld;
   logic [31:0] din;

   logic [1:0]  o_valid_a, o_inj_a, o_dbit_a;
   logic [31:0] o_data_a, o_cnt_a;
   logic [1:0]  o_valid_b, o_inj_b, o_dbit_b;
   logic [31:0] o_data_b;
   logic [7:0]  o_cnt_b;

   int n_vec = 0;
   int n_err = 0;

   err_inj_gen dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_mode(cfg_mode),
      .i_cfg_rand(cfg_rand), .i_cfg_oneshot(cfg_oneshot), .i_cfg_pos0(cfg_pos0),
      .i_cfg_pos1(cfg_pos1), .i_cfg_period(cfg_period), .i_cfg_ch_en(cfg_ch_en),
      .i_valid(vld), .i_data(din), .o_valid(o_valid_a), .o_data(o_data_a),
      .o_inj(o_inj_a), .o_dbit(o_dbit_a), .o_inj_cnt(o_cnt_a)
   );

   // Narrow-counter instance sharing the same stimulus, for saturation at 15.
   err_inj_gen #(.CNT_W(4)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_mode(cfg_mode),
      .i_cfg_rand(cfg_rand), .i_cfg_oneshot(cfg_oneshot), .i_cfg_pos0(cfg_pos0),
      .i_cfg_pos1(cfg_pos1), .i_cfg_period(cfg_period[3:0]), .i_cfg_ch_en(cfg_ch_en),
      .i_valid(vld), .i_data(din), .o_valid(o_valid_b), .o_data(o_data_b),
      .o_inj(o_inj_b), .o_dbit(o_dbit_b), .o_inj_cnt(o_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   int          m_mode, m_period, m_p0, m_p1;
   bit          m_rand, m_oneshot;
   bit   [1:0]  m_armed;
   int          m_beats [2];
   int          m_cnt   [2];
   logic [15:0] m_lfsr;
   logic [1:0]  exp_valid, exp_inj, exp_dbit;
   logic [31:0] exp_data;

   always @(posedge clk) begin : model_cmp
      logic [15:0] mask;
      int peff, r, rp0, rp1, pa, pb;
      if (!rst_n) begin
         m_mode = 0; m_period = 0; m_p0 = 0; m_p1 = 0; m_rand = 0; m_oneshot = 0;
         m_armed = '0; m_lfsr = 16'hACE1;
         for (int c = 0; c < 2; c++) begin m_beats[c] = 0; m_cnt[c] = 0; end
         exp_valid = '0; exp_inj = '0; exp_dbit = '0; exp_data = '0;
      end else begin
         peff = (m_period == 0) ? 1 : m_period;
         r    = int'(m_lfsr) % 16;
         rp0  = r % DW;
         rp1  = (rp0 + 1) % DW;
         for (int c = 0; c < 2; c++) begin
            mask = '0;
            if (vld[c] && m_armed[c]) begin
               m_beats[c]++;
               if (m_beats[c] % peff == 0) begin
                  pa = m_rand ? rp0 : m_p0;
                  pb = m_rand ? rp1 : m_p1;
                  if (pa < DW) mask[pa] = 1'b1;
                  if (m_mode == 2 && pb < DW) mask[pb] = 1'b1;
                  if (m_oneshot) m_armed[c] = 1'b0;
               end
            end
            exp_valid[c]          = vld[c];
            exp_data[c*16 +: 16]  = din[c*16 +: 16] ^ mask;
            exp_inj[c]            = (mask != 0);
            exp_dbit[c]           = ($countones(mask) == 2);
            if (mask != 0) m_cnt[c]++;
         end
         if (cfg_we) begin
            m_mode = int'(cfg_mode); m_rand = cfg_rand; m_oneshot = cfg_oneshot;
            m_p0 = int'(cfg_pos0); m_p1 = int'(cfg_pos1); m_period = int'(cfg_period);
            for (int c = 0; c < 2; c++) begin
               m_armed[c] = (cfg_mode == 2'b01 || cfg_mode == 2'b10) && cfg_ch_en[c];
               m_beats[c] = 0;
            end
         end
         m_lfsr = lfsr_step(m_lfsr);
      end
      #1;
      check("valid_a", 64'(o_valid_a), 64'(exp_valid));
      check("data_a",  64'(o_data_a),  64'(exp_data));
      check("inj_a",   64'(o_inj_a),   64'(exp_inj));
      check("dbit_a",  64'(o_dbit_a),  64'(exp_dbit));
      check("cnt_a",   64'(o_cnt_a),   64'({16'(sat(m_cnt[1], 65535)), 16'(sat(m_cnt[0], 65535))}));
      check("valid_b", 64'(o_valid_b), 64'(exp_valid));
      check("data_b",  64'(o_data_b),  64'(exp_data));
      check("inj_b",   64'(o_inj_b),   64'(exp_inj));
      check("dbit_b",  64'(o_dbit_b),  64'(exp_dbit));
      check("cnt_b",   64'(o_cnt_b),   64'({4'(sat(m_cnt[1], 15)), 4'(sat(m_cnt[0], 15))}));
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input logic [1:0] v, input logic [31:0] d);
      @(negedge clk);
      cfg_we = 1'b0; vld = v; din = d;
      @(posedge clk); #2;
   endtask

   task automatic cfg(input logic [1:0] mode, input logic rnd, input logic os,
                      input logic [3:0] p0, input logic [3:0] p1,
                      input logic [15:0] per, input logic [1:0] en);
      @(negedge clk);
      cfg_we = 1'b1; cfg_mode = mode; cfg_rand = rnd; cfg_oneshot = os;
      cfg_pos0 = p0; cfg_pos1 = p1; cfg_period = per; cfg_ch_en = en;
      vld = '0;
      @(posedge clk); #2;
   endtask

   initial begin
      int n_inj, first;
      rst_n = 1'b0; cfg_we = 0; cfg_mode = 0; cfg_rand = 0; cfg_oneshot = 0;
      cfg_pos0 = 0; cfg_pos1 = 0; cfg_period = 0; cfg_ch_en = 0; vld = 0; din = 0;
      repeat (2) @(negedge clk);
      check("reset_data", 64'(o_data_a), 64'h0);
      check("reset_cnt",  64'(o_cnt_a),  64'h0);
      rst_n = 1'b1;

      // Mode OFF: passthrough.
      beat(2'b01, 32'h0000_1234);
      check("off_data", 64'(o_data_a[15:0]), 64'h1234);
      check("off_inj",  64'(o_inj_a), 64'h0);
      check("off_cnt",  64'(o_cnt_a), 64'h0);

      // SINGLE fixed p0=3, every beat, ch0 only.
      cfg(2'b01, 0, 0, 4'd3, 4'd0, 16'd1, 2'b01);
      for (int i = 0; i < 4; i++) begin
         beat(2'b11, {16'($urandom), 16'h0000});
         check("single_data", 64'(o_data_a[15:0]), 64'h0008);
         check("single_dbit", 64'(o_dbit_a[0]), 64'h0);
      end
      check("single_cnt0", 64'(o_cnt_a[15:0]), 64'd4);
      check("single_cnt1", 64'(o_cnt_a[31:16]), 64'd0);

      // DOUBLE p0=0 p1=15 period 3.
      cfg(2'b10, 0, 0, 4'd0, 4'd15, 16'd3, 2'b11);
      for (int i = 1; i <= 6; i++) begin
         beat(2'b11, 32'hFFFF_FFFF);
         check("double_data", 64'(o_data_a[15:0]), (i % 3 == 0) ? 64'h7FFE : 64'hFFFF);
         check("double_dbit", 64'(o_dbit_a[0]), (i % 3 == 0) ? 64'h1 : 64'h0);
      end
      cfg(2'b10, 0, 0, 4'd5, 4'd5, 16'd1, 2'b01);
      beat(2'b01, 32'h0000_FFFF);
      check("same_pos_data", 64'(o_data_a[15:0]), 64'hFFDF);
      check("same_pos_inj",  64'(o_inj_a[0]), 64'h1);
      check("same_pos_dbit", 64'(o_dbit_a[0]), 64'h0);

      // Oneshot, period 2.
      cfg(2'b01, 0, 1, 4'd2, 4'd0, 16'd2, 2'b01);
      n_inj = 0; first = 0;
      for (int i = 1; i <= 10; i++) begin
         beat(2'b01, $urandom);
         if (o_inj_a[0]) begin n_inj++; first = i; end
      end
      check("oneshot_count", 64'(n_inj), 64'd1);
      check("oneshot_beat",  64'(first), 64'd2);
      cfg(2'b01, 0, 1, 4'd2, 4'd0, 16'd2, 2'b01);
      beat(2'b01, 32'h0);
      beat(2'b01, 32'h0);
      check("rearm_inj", 64'(o_inj_a[0]), 64'h1);

      // Configuration write coincident with a beat: beat keeps old config.
      cfg(2'b01, 0, 0, 4'd0, 4'd0, 16'd1, 2'b01);
      @(negedge clk);
      cfg_we = 1'b1; cfg_pos0 = 4'd7; vld = 2'b01; din = 32'h0;
      @(posedge clk); #2;
      check("coincident_old", 64'(o_data_a[15:0]), 64'h0001);
      beat(2'b01, 32'h0);
      check("coincident_new", 64'(o_data_a[15:0]), 64'h0080);

      // Saturation of the 4-bit counters.
      cfg(2'b01, 0, 0, 4'd1, 4'd0, 16'd1, 2'b11);
      repeat (20) beat(2'b11, $urandom);
      check("sat4_cnt", 64'(o_cnt_b), 64'hFF);

      // Random DOUBLE straight after reset: pinned LFSR values E270, 7138.
      @(negedge clk);
      rst_n = 1'b0; cfg_we = 1'b0; vld = '0;
      @(negedge clk);
      rst_n = 1'b1; cfg_we = 1'b1; cfg_mode = 2'b10; cfg_rand = 1'b1; cfg_oneshot = 1'b0;
      cfg_period = 16'd1; cfg_ch_en = 2'b01;
      beat(2'b01, 32'h0);
      check("rand_pin0", 64'(o_data_a[15:0]), 64'h0003);
      beat(2'b01, 32'h0);
      check("rand_pin1", 64'(o_data_a[15:0]), 64'h0300);
      repeat (300) beat(2'($urandom), $urandom);

      // Randomized configuration and traffic.
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         cfg_we = ($urandom_range(0, 19) == 0);
         if (cfg_we) begin
            cfg_mode    = 2'($urandom);
            cfg_rand    = 1'($urandom);
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            cfg_pos0    = 4'($urandom);
            cfg_pos1    = 4'($urandom);
            cfg_period  = 16'($urandom_range(0, 5));
            cfg_ch_en   = 2'($urandom);
         end
         vld = 2'($urandom);
         din = $urandom;
      end

      // Mid-stream reset clears outputs immediately.
      beat(2'b11, $urandom);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 64'(o_valid_a), 64'h0);
      check("midrst_data",  64'(o_data_a),  64'h0);
      check("midrst_inj",   64'(o_inj_a),   64'h0);
      check("midrst_cnt_a", 64'(o_cnt_a),   64'h0);
      check("midrst_cnt_b", 64'(o_cnt_b),   64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; cfg_we = 1'b0; vld = 2'b11; din = 32'hABCD_1234;
      @(posedge clk); #2;
      check("postrst_data", 64'(o_data_a), 64'hABCD_1234);
      check("postrst_inj",  64'(o_inj_a),  64'h0);
      repeat (3) beat(2'($urandom), $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/err_inj_gen.md
# err_inj_gen

Sequential, multi-channel error-injection generator for the Hamming-protected memory path. It sits between the Hamming encoder outputs and the memory write ports and registers NUM_CH encoded words. Under configuration it flips one or two bits on a programmable beat period, with fixed or pseudo-random bit positions. It reports per-beat injection and double-bit flags plus saturating per-channel injection counts for scoreboarding.

## Interface
Parameters:
- DATA_W, 16: width of one Hamming-encoded word.
- NUM_CH, 2: number of independent channels (port-a = ch 0, port-b = ch 1).
- CNT_W, 16: width of period counters and injection counters.
- POS_W, $clog2(DATA_W): width of a bit-position field.
- LFSR_SEED, 16'hACE1: reset value of the shared 16-bit LFSR. 0 is replaced by 16'h0001.

Ports (clock and reset first):
- i_clk, input, 1: single clock, rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_cfg_we, input, 1: configuration write strobe.
- i_cfg_mode, input, 2: 00 OFF, 01 SINGLE, 10 DOUBLE, 11 reserved (treated as OFF).
- i_cfg_rand, input, 1: 1 = positions from LFSR, 0 = positions from i_cfg_pos0/1.
- i_cfg_oneshot, input, 1: 1 = inject once per channel, then disarm.
- i_cfg_pos0, input, POS_W: first fixed bit position.
- i_cfg_pos1, input, POS_W: second fixed bit position (DOUBLE only).
- i_cfg_period, input, CNT_W: inject on every Nth valid beat. 0 and 1 both mean every beat.
- i_cfg_ch_en, input, NUM_CH: per-channel enable.
- i_valid, input, NUM_CH: per-channel beat valid.
- i_data, input, NUM_CH*DATA_W: encoded words. Channel c occupies [c*DATA_W +: DATA_W].
- o_valid, output, NUM_CH: registered copy of i_valid.
- o_data, output, NUM_CH*DATA_W: i_data XOR injection mask, registered.
- o_inj, output, NUM_CH: mask applied to this beat was non-zero.
- o_dbit, output, NUM_CH: exactly two bits flipped on this beat.
- o_inj_cnt, output, NUM_CH*CNT_W: saturating count of beats with o_inj=1.

## Operation
- Per-channel FSM with states IDLE, ARMED, DONE. Reset state is IDLE.
  - IDLE → ARMED on i_cfg_we with a non-OFF mode and i_cfg_ch_en[c]=1.
  - ARMED → DONE after an injecting beat when oneshot=1.
  - Any state → IDLE on i_cfg_we with mode OFF or ch_en[c]=0.
  - i_cfg_we from ARMED or DONE with a valid mode re-arms to ARMED.
- Period counter (per channel): increments on each i_valid beat while ARMED.
  - An injecting beat is one where counter == max(period,1)-1. The counter then wraps to 0.
  - Counter is cleared on every i_cfg_we.
- Mask:
  - SINGLE: 1<<p0.
  - DOUBLE: (1<<p0) | (1<<p1).
  - Any position ≥ DATA_W contributes no bit.
  - In DOUBLE with p0==p1, one bit flips: o_inj=1, o_dbit=0.
- Random positions:
  - r = lfsr[POS_W-1:0]. p0 = r if r < DATA_W, else r-DATA_W.
  - p1 = p0+1, wrapping to 0 at DATA_W.
  - Every channel uses the same LFSR value in a given cycle.
- LFSR: 16-bit Galois, taps 16'hB400, free-running, advances every cycle after reset.
- Non-injecting and invalid beats pass i_data through unmodified, with o_inj=o_dbit=0.
- o_inj_cnt increments on each injecting beat and holds at all-ones. Only reset clears it.

## Timing
- Latency is 1 cycle from i_valid/i_data to o_valid/o_data/o_inj/o_dbit. No back-pressure.
- Reset values: o_valid=0, o_data=0, o_inj=0, o_dbit=0, o_inj_cnt=0, FSMs IDLE, counters 0, LFSR=seed.
- Configuration is applied to beats in the cycle after i_cfg_we.
- If i_cfg_we and i_valid occur in the same cycle, the beat uses the old configuration and state. The counter clear and the state change win over that beat's increment.
- Reset asserted mid-stream clears all outputs asynchronously. The first beat after deassertion passes unmodified unless a configuration has been written.

## Structure
- Package err_inj_pkg holds:
  - enum mode_e (OFF, SINGLE, DOUBLE, RSVD);
  - enum state_e (IDLE, ARMED, DONE);
  - localparam LFSR_TAPS = 16'hB400;
  - function pos_wrap().
- Sub-module err_inj_lane: one channel, containing the FSM, period counter, mask build, output register and injection counter. NUM_CH instances are generated.
- The top level owns the shared LFSR and the configuration fan-out.

## Test plan
- Reset, then mode OFF, with i_data ch0=16'h1234 valid → o_data=16'h1234 one cycle later, o_inj=0, o_inj_cnt=0.
- SINGLE, fixed p0=3, period=1, ch_en=2'b01, ch0 data 16'h0000 for 4 beats → o_data=16'h0008 each beat, o_dbit=0, o_inj_cnt[0]=4. Ch1 passes unmodified.
- DOUBLE, p0=0, p1=15, period=3, data 16'hFFFF for 6 beats → beats 3 and 6 are 16'h7FFE with o_dbit=1. Other beats are 16'hFFFF. Then p0=p1=5 → a single flip with o_dbit=0.
- oneshot=1, SINGLE, period=2, 10 beats → exactly one injection on beat 2, o_inj_cnt=1. A re-write of the configuration re-arms and gives a second injection.
- Random DOUBLE with default seed → compare against a reference-model LFSR. Every flipped position is < DATA_W and the two positions are adjacent modulo DATA_W.
- Boundary cases:
  - i_cfg_we coincident with a valid beat → that beat uses the old configuration.
  - Counter saturation with CNT_W=4 → o_inj_cnt holds at 15.
  - i_rst_n pulsed mid-stream → outputs go to 0 immediately.
